// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared FSM state type and counter-width helper for count_ctrl
//
// Contents:
//   state_t   - control FSM states (ST_IDLE, ST_RUN, ST_PAUSE)
//   cnt_width - bits needed for a counter that spans 0..n-1
package count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Width of a counter holding 0..n-1. Never below one bit, so that a
    // divide-by-2 prescaler or a single-cycle debounce still elaborates.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// rtl/count_ctrl_if.sv - board-side signal bundle between the panel and count_ctrl
//
// Signals:
//   btn_start_stop, btn_clear - raw push-buttons, high = pressed
//   sw_dir                    - count direction switch, 1 = up
//   sw_load                   - preset-load enable switch, level-sensitive
//   load_val[N-1:0]           - preset value from the switches
//   count_out[N-1:0]          - registered count towards the display stage
//   running                   - FSM is in RUN
//   wrap                      - one-cycle pulse when a tick wraps the count
// Modports:
//   master - the board / panel side that drives buttons and switches
//   slave  - count_ctrl itself
interface count_ctrl_if #(
    parameter int N = 10
);

    logic         btn_start_stop;
    logic         btn_clear;
    logic         sw_dir;
    logic         sw_load;
    logic [N-1:0] load_val;
    logic [N-1:0] count_out;
    logic         running;
    logic         wrap;

    modport master (
        output btn_start_stop,
        output btn_clear,
        output sw_dir,
        output sw_load,
        output load_val,
        input  count_out,
        input  running,
        input  wrap
    );

    modport slave (
        input  btn_start_stop,
        input  btn_clear,
        input  sw_dir,
        input  sw_load,
        input  load_val,
        output count_out,
        output running,
        output wrap
    );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, debouncer and press-pulse generator
//
// Parameters:
//   DEB_CYCLES - consecutive disagreeing cycles needed before the level flips
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   raw   - asynchronous button input, high = pressed
//   level - debounced button level
//   press - one-cycle pulse on each 0->1 transition of level
module btn_debounce
    import count_pkg::*;
#(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level_d;
    logic [CW-1:0] diff_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            press    <= 1'b0;
            diff_cnt <= '0;
        end else begin
            sync_1  <= raw;
            sync_2  <= sync_1;
            level_d <= level;
            // Registered edge detect: the pulse appears the cycle after
            // the level flips and is exactly one cycle wide.
            press   <= level & ~level_d;

            // diff_cnt counts consecutive cycles in which the synchronised
            // input disagrees with the accepted level; any agreeing cycle
            // throws the partial count away, so bounces never accumulate.
            if (sync_2 != level) begin
                if (diff_cnt == DEB_LAST) begin
                    level    <= sync_2;
                    diff_cnt <= '0;
                end else begin
                    diff_cnt <= diff_cnt + CW'(1);
                end
            end else begin
                diff_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - prescaled up/down event counter with start/stop/clear control
//
// Parameters:
//   N          - count width, equal to the display stage input width
//   CLK_HZ     - system clock frequency
//   TICK_HZ    - count rate while running; DIV = CLK_HZ / TICK_HZ (>= 2)
//   MAX_COUNT  - wrap limit, < 2**N and <= 9999
//   DEB_CYCLES - button debounce stable-cycle requirement
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - count_ctrl_if slave: buttons, switches, preset in; count,
//           running and wrap out
module count_ctrl
    import count_pkg::*;
#(
    parameter int N          = 10,
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 10,
    parameter int MAX_COUNT  = 999,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic         clk,
    input  logic         rst_n,
    count_ctrl_if.slave  bus
);

    localparam int            DIV      = CLK_HZ / TICK_HZ;
    localparam int            PW       = cnt_width(DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic [N-1:0]  MAX_VAL  = N'(MAX_COUNT);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic ss_level;
    logic ss_press;
    logic clr_level;
    logic clr_press;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_start_stop (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_start_stop),
        .level (ss_level),
        .press (ss_press)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_clear),
        .level (clr_level),
        .press (clr_press)
    );

    // Only the press pulses steer the FSM; the debounced levels are
    // gathered here so they are visibly consumed.
    logic unused_levels;
    assign unused_levels = ss_level | clr_level;

    // ------------------------------------------------------------------
    // Switch synchronisers
    // ------------------------------------------------------------------
    logic dir_s1;
    logic dir_s2;
    logic load_s1;
    logic load_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_s1  <= 1'b0;
            dir_s2  <= 1'b0;
            load_s1 <= 1'b0;
            load_s2 <= 1'b0;
        end else begin
            dir_s1  <= bus.sw_dir;
            dir_s2  <= dir_s1;
            load_s1 <= bus.sw_load;
            load_s2 <= load_s1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ss_press) state_next = ST_RUN;
            ST_RUN:   if (ss_press) state_next = ST_PAUSE;
            ST_PAUSE: if (ss_press) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
        // Clear wins over a start/stop press arriving in the same cycle.
        if (clr_press) begin
            state_next = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: runs in RUN, keeps its phase in PAUSE, zero in IDLE
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (state == ST_RUN) && (presc == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else begin
            case (state)
                ST_RUN:   presc <= tick ? '0 : presc + PW'(1);
                ST_PAUSE: presc <= presc;
                default:  presc <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Count datapath
    // ------------------------------------------------------------------
    logic [N-1:0] count_q;
    logic         wrap_q;
    logic         running_q;
    logic [N-1:0] load_clamped;

    assign load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            wrap_q    <= 1'b0;
            // Decoded from the next state so running changes on the same
            // edge as the state register, from a flop rather than gates.
            running_q <= (state_next == ST_RUN);

            if (clr_press) begin
                // Clear also swallows a coincident tick and its wrap.
                count_q <= '0;
            end else if (tick) begin
                // Bounds are compared before stepping so the count never
                // relies on N-bit overflow to come back into range.
                if (dir_s2) begin
                    if (count_q == MAX_VAL) begin
                        count_q <= '0;
                        wrap_q  <= 1'b1;
                    end else begin
                        count_q <= count_q + N'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_q <= MAX_VAL;
                        wrap_q  <= 1'b1;
                    end else begin
                        count_q <= count_q - N'(1);
                    end
                end
            end else if ((state != ST_RUN) && load_s2) begin
                count_q <= load_clamped;
            end
        end
    end

    assign bus.count_out = count_q;
    assign bus.running   = running_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - self-checking bench for count_ctrl
module tb_count_ctrl;

    localparam int N          = 10;
    localparam int CLK_HZ     = 100;
    localparam int TICK_HZ    = 10;
    localparam int DIV        = CLK_HZ / TICK_HZ;
    localparam int MAX_COUNT  = 15;
    localparam int DEB_CYCLES = 4;
    // Raw button edge to FSM update: 2 sync + DEB_CYCLES + press reg + FSM.
    localparam int PRESS_LAT  = 2 + DEB_CYCLES + 1 + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    count_ctrl_if #(.N(N)) bus ();

    count_ctrl #(
        .N          (N),
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .MAX_COUNT  (MAX_COUNT),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;

    // Reference model: mode 0 idle, 1 run, 2 pause. Ticks are derived from
    // the number of RUN cycles since leaving IDLE, and button effects are
    // scheduled at the known press latency rather than re-debounced.
    int  m_mode  = 0;
    int  m_count = 0;
    int  m_runs  = 0;
    bit  m_wrap  = 0;
    bit  dir_d1  = 0;
    bit  dir_d2  = 0;
    bit  ld_d1   = 0;
    bit  ld_d2   = 0;
    int  ss_q[$];
    int  clr_q[$];

    typedef struct {
        logic [N-1:0] load_val;
        int           exp_count;
    } load_vec_t;

    load_vec_t lv_tab[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic model_edge();
        bit ss, clr, tick, dir_eff, ld_eff;
        int lv;
        if (!rst_n) begin
            m_mode = 0; m_count = 0; m_runs = 0; m_wrap = 0;
            dir_d1 = 0; dir_d2 = 0; ld_d1 = 0; ld_d2 = 0;
            ss_q.delete();
            clr_q.delete();
        end else begin
            ss  = (ss_q.size() > 0) && (ss_q[0] == ecnt);
            clr = (clr_q.size() > 0) && (clr_q[0] == ecnt);
            if (ss)  ss_q.delete(0);
            if (clr) clr_q.delete(0);
            dir_eff = dir_d2;
            ld_eff  = ld_d2;
            dir_d2  = dir_d1;
            dir_d1  = bus.sw_dir;
            ld_d2   = ld_d1;
            ld_d1   = bus.sw_load;
            lv      = int'(bus.load_val);
            m_wrap  = 0;
            tick    = 0;
            if (m_mode == 1) begin
                m_runs++;
                tick = (m_runs % DIV) == 0;
            end
            if (clr) begin
                m_count = 0;
            end else if (tick) begin
                if (dir_eff) begin
                    m_wrap  = (m_count == MAX_COUNT);
                    m_count = m_wrap ? 0 : m_count + 1;
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = m_wrap ? MAX_COUNT : m_count - 1;
                end
            end else if (m_mode != 1 && ld_eff) begin
                m_count = (lv > MAX_COUNT) ? MAX_COUNT : lv;
            end
            if (clr)     m_mode = 0;
            else if (ss) m_mode = (m_mode == 1) ? 2 : 1;
            if (m_mode == 0) m_runs = 0;
        end
    endtask

    // One clock: model steps on the rising edge, DUT compared on the falling.
    task automatic cycle();
        @(posedge clk);
        ecnt++;
        model_edge();
        @(negedge clk);
        chk("model_count",   int'(bus.count_out), m_count);
        chk("model_running", int'(bus.running),   (m_mode == 1) ? 1 : 0);
        chk("model_wrap",    int'(bus.wrap),      int'(m_wrap));
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic btn_down(input bit ss, input bit clr);
        if (ss) begin
            bus.btn_start_stop = 1'b1;
            ss_q.push_back(ecnt + PRESS_LAT);
        end
        if (clr) begin
            bus.btn_clear = 1'b1;
            clr_q.push_back(ecnt + PRESS_LAT);
        end
    endtask

    task automatic btn_up();
        bus.btn_start_stop = 1'b0;
        bus.btn_clear      = 1'b0;
    endtask

    task automatic press(input bit ss, input bit clr);
        btn_down(ss, clr);
        wait_cycles(PRESS_LAT);
        btn_up();
        wait_cycles(PRESS_LAT);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, expected end before it", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        lv_tab[0] = '{10'd3,    3};
        lv_tab[1] = '{10'd0,    0};
        lv_tab[2] = '{10'd15,   15};
        lv_tab[3] = '{10'd16,   15};
        lv_tab[4] = '{10'd20,   15};
        lv_tab[5] = '{10'd1023, 15};
        lv_tab[6] = '{10'd9,    9};
        lv_tab[7] = '{10'd14,   14};

        bus.btn_start_stop = 1'b0;
        bus.btn_clear      = 1'b0;
        bus.sw_dir         = 1'b0;
        bus.sw_load        = 1'b0;
        bus.load_val       = '0;
        rst_n              = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        chk("reset_count",   int'(bus.count_out), 0);
        chk("reset_running", int'(bus.running),   0);
        chk("reset_wrap",    int'(bus.wrap),      0);

        // Start latency and first steps
        bus.sw_dir = 1'b1;
        wait_cycles(3);
        btn_down(1, 0);
        wait_cycles(PRESS_LAT - 1);
        chk("start_latency_early", int'(bus.running), 0);
        cycle();
        chk("start_latency", int'(bus.running), 1);
        btn_up();
        wait_cycles(DIV - 1);
        chk("step0_hold", int'(bus.count_out), 0);
        cycle();
        chk("step1", int'(bus.count_out), 1);
        wait_cycles(DIV);
        chk("step2", int'(bus.count_out), 2);

        // Load clamp table in IDLE
        press(0, 1);
        chk("clear_to_idle", int'(bus.running), 0);
        bus.sw_load = 1'b1;
        wait_cycles(2);
        for (int i = 0; i < 8; i++) begin
            bus.load_val = lv_tab[i].load_val;
            cycle();
            chk($sformatf("load_tab[%0d]", i), int'(bus.count_out), lv_tab[i].exp_count);
        end
        bus.sw_load = 1'b0;
        wait_cycles(3);

        // Up wrap from 14
        btn_down(1, 0);
        wait_cycles(PRESS_LAT);
        btn_up();
        chk("up_run", int'(bus.running), 1);
        wait_cycles(DIV - 1);
        chk("up_hold14", int'(bus.count_out), 14);
        cycle();
        chk("up_15", int'(bus.count_out), 15);
        chk("up_15_nowrap", int'(bus.wrap), 0);
        wait_cycles(DIV - 1);
        chk("up_hold15", int'(bus.count_out), 15);
        cycle();
        chk("up_wrap_count", int'(bus.count_out), 0);
        chk("up_wrap_pulse", int'(bus.wrap), 1);
        cycle();
        chk("up_wrap_one_cycle", int'(bus.wrap), 0);

        // Down wrap from 1, load ignored in RUN, pause/resume phase
        press(0, 1);
        bus.sw_dir   = 1'b0;
        bus.sw_load  = 1'b1;
        bus.load_val = 10'd1;
        wait_cycles(3);
        chk("down_preload", int'(bus.count_out), 1);
        bus.sw_load = 1'b0;
        wait_cycles(3);
        btn_down(1, 0);
        wait_cycles(PRESS_LAT);
        btn_up();
        chk("down_run", int'(bus.running), 1);
        wait_cycles(2);
        bus.sw_load  = 1'b1;
        bus.load_val = 10'd7;
        wait_cycles(4);
        bus.sw_load = 1'b0;
        wait_cycles(2);
        chk("run_load_ignored", int'(bus.count_out), 1);
        wait_cycles(2);
        chk("down_step", int'(bus.count_out), 0);
        wait_cycles(5);
        btn_down(1, 0);
        wait_cycles(5);
        chk("down_wrap_count", int'(bus.count_out), MAX_COUNT);
        chk("down_wrap_pulse", int'(bus.wrap), 1);
        wait_cycles(3);
        chk("paused", int'(bus.running), 0);
        btn_up();
        bus.sw_load  = 1'b1;
        bus.load_val = 10'd5;
        wait_cycles(3);
        chk("pause_load", int'(bus.count_out), 5);
        bus.load_val = 10'd20;
        cycle();
        chk("pause_clamp", int'(bus.count_out), 15);
        bus.sw_load = 1'b0;
        wait_cycles(8);
        btn_down(1, 0);
        wait_cycles(PRESS_LAT);
        btn_up();
        chk("resume", int'(bus.running), 1);
        wait_cycles(DIV - 3 - 1);
        chk("resume_hold", int'(bus.count_out), 15);
        cycle();
        chk("resume_step", int'(bus.count_out), 14);

        // Bounce rejection while running
        for (int i = 0; i < 10; i++) begin
            bus.btn_start_stop = ~bus.btn_start_stop;
            wait_cycles(2);
        end
        wait_cycles(PRESS_LAT);
        chk("bounce_reject", int'(bus.running), 1);

        // Clear and start/stop together in RUN
        btn_down(1, 1);
        wait_cycles(PRESS_LAT);
        chk("clr_pri_running", int'(bus.running), 0);
        chk("clr_pri_count", int'(bus.count_out), 0);
        btn_up();
        wait_cycles(PRESS_LAT);

        // Reset mid-run at count 9
        bus.sw_dir = 1'b1;
        wait_cycles(3);
        btn_down(1, 0);
        wait_cycles(PRESS_LAT);
        btn_up();
        wait_cycles(9 * DIV + 3);
        chk("pre_reset_count", int'(bus.count_out), 9);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midrst_count",   int'(bus.count_out), 0);
        chk("midrst_running", int'(bus.running),   0);
        chk("midrst_wrap",    int'(bus.wrap),      0);
        wait_cycles(8);
        btn_down(1, 0);
        wait_cycles(PRESS_LAT);
        btn_up();
        chk("restart_run", int'(bus.running), 1);
        wait_cycles(DIV);
        chk("restart_step", int'(bus.count_out), 1);

        // Randomised operation against the model
        for (int op = 0; op < 80; op++) begin
            case ($urandom_range(0, 5))
                0: wait_cycles(int'($urandom_range(1, 30)));
                1: begin
                    bus.sw_dir = ~bus.sw_dir;
                    cycle();
                end
                2, 5: press(1, 0);
                3: begin
                    if ($urandom_range(0, 3) == 0) press(0, 1);
                    else wait_cycles(int'($urandom_range(1, 12)));
                end
                default: begin
                    bus.load_val = N'($urandom_range(0, 31));
                    bus.sw_load  = 1'b1;
                    wait_cycles(int'($urandom_range(1, 6)));
                    bus.sw_load = 1'b0;
                    cycle();
                end
            endcase
        end
        wait_cycles(DIV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Prescaled up/down event counter that produces the binary value driven into the BCD/7-segment display stage (`N`-bit input, four digit outputs). It turns two raw push-buttons (start/stop, clear) and board switches (direction, preset load) into a registered count that advances at `TICK_HZ`. The count wraps within `0..MAX_COUNT`. `count_out` connects directly to the display stage's binary input, with a matching width `N`.

## Interface
Parameters:
- `N`, 10, count width; must equal the display stage's input width.
- `CLK_HZ`, 50_000_000, system clock frequency.
- `TICK_HZ`, 10, count rate while running; `DIV = CLK_HZ/TICK_HZ` (≥2).
- `MAX_COUNT`, 999, wrap limit; must be < 2^N and ≤ 9999.
- `DEB_CYCLES`, 500_000, stable-cycles requirement for button debounce.

Ports:
- `clk`, in, 1: single system clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `btn_start_stop`, in, 1: raw asynchronous push-button; high = pressed.
- `btn_clear`, in, 1: raw asynchronous push-button; high = pressed.
- `sw_dir`, in, 1: count direction; 1 = up, 0 = down. Raw switch, 2-flop synchronised.
- `sw_load`, in, 1: preset-load enable, level-sensitive. Raw switch, 2-flop synchronised.
- `load_val`, in, N: preset value from the switches; quasi-static, sampled with `sw_load`.
- `count_out`, out, N: registered count; feeds the display stage.
- `running`, out, 1: high when the FSM is in RUN.
- `wrap`, out, 1: one-cycle pulse when a tick wraps the count.

## Operation
- **Button conditioning:** each button passes through a 2-flop synchroniser and then a debouncer.
  - The debounced level flips only after the synchronised level has differed from it for `DEB_CYCLES` consecutive cycles.
  - Any disagreement-free cycle restarts that count.
  - A 0→1 transition of the debounced level produces one press pulse, exactly one cycle wide.
- **FSM states:** IDLE, RUN, PAUSE. Reset state is IDLE.
  - start_stop pulse: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - clear pulse: any state → IDLE, and `count_out` becomes 0.
  - Priority: clear > start_stop.
- **Prescaler:** counts `0..DIV-1` while in RUN and emits an internal tick when it reaches `DIV-1`, then returns to 0.
  - Held in PAUSE, so the phase is kept.
  - Forced to 0 in IDLE.
- **Tick in RUN:**
  - `sw_dir`=1: `count==MAX_COUNT` → 0 with `wrap`=1; otherwise +1.
  - `sw_dir`=0: `count==0` → `MAX_COUNT` with `wrap`=1; otherwise −1.
- **Load:** in IDLE or PAUSE with `sw_load`=1, the count is set to `min(load_val, MAX_COUNT)` every cycle.
  - Ignored in RUN.
  - Clear overrides load in the same cycle.
- **Simultaneous events:**
  - Clear and tick in the same cycle → count 0, `wrap`=0.
  - start_stop and tick in the same cycle while in RUN → the tick is applied, then the FSM enters PAUSE.
- **Count range:** `count_out` never leaves `0..MAX_COUNT`.
- **Arithmetic:** all arithmetic is N-bit unsigned with explicit compare-before-step; modular overflow is never relied on.

## Timing
- Reset (`rst_n`=0 at a clock edge): `count_out`=0, `running`=0, `wrap`=0, state IDLE, prescaler 0, debounced levels 0, synchronisers 0. The same values apply on reset mid-count.
- Press latency: the press pulse is asserted `2 + DEB_CYCLES + 1` cycles after a clean rising edge on the raw button.
- FSM and `running` update in the cycle after the press pulse.
- `count_out` and `wrap` update in the cycle after the internal tick.
- In continuous RUN, consecutive count updates are exactly `DIV` cycles apart.
- Load: `count_out` reflects the preset one cycle after synchronised `sw_load` is high.
- `running` does not glitch: it is a registered state decode.

## Structure
- Shared package `count_pkg`: FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_PAUSE`) and a function computing the prescaler width from `DIV`.
- Sub-module `btn_debounce`: parameter `DEB_CYCLES`; ports clk, rst_n, raw, level, press. Instantiated twice.
- Prescaler, FSM and count datapath live in `count_ctrl`.

## Test plan
Bench parameters: `CLK_HZ`=100, `TICK_HZ`=10 (DIV=10), `DEB_CYCLES`=4, `MAX_COUNT`=15.
- **Reset / start / step:** reset, then press start_stop → `running`=1 at cycle 2+4+1+1 after the press; `count_out` steps 0→1→2 at 10-cycle intervals.
- **Up wrap:** `sw_dir`=1 from a load of 14 → 14→15→0 with `wrap` high for exactly one cycle at the 15→0 step.
- **Down wrap:** `sw_dir`=0 from count 1 → 1→0→15 with `wrap` pulsed on the 0→15 step.
- **Load and pause:** `load_val`=20 in PAUSE → count 15 (clamped); `load_val`=7 in RUN → ignored. Pause after 3 prescaler cycles, resume → next step after the remaining 7 cycles.
- **Bounce rejection and clear priority:**
  - Raw button toggling every 2 cycles for 20 cycles → no press pulse.
  - clear and start_stop pulses in the same cycle while in RUN → IDLE, count 0, `running`=0.
- **Mid-run reset:** `rst_n` low for one edge at count 9 while running → all outputs at their reset values on the next cycle; the bench then counts again from 0 after a new start.
